// File: rtl/spi_master_param_if.sv
// Host-side and serial-bus signals of spi_master_param; the master modport faces the SPI master,
// the slave modport faces whatever drives the host side and the MISO line.
interface spi_master_param_if #(
  parameter int DATA_W = 8,
  parameter int N_SS   = 4,
  parameter int SEL_W  = 2,
  parameter int DIV_W  = 8
);
  logic              CPH;
  logic              CKP;
  logic              strt;
  logic [DIV_W-1:0]  div;
  logic [SEL_W-1:0]  ss_sel;
  logic [DATA_W-1:0] data_in;
  logic              MISO;
  logic [N_SS-1:0]   CS;
  logic              MOSI;
  logic              SCK;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              busy;

  modport master (
    input  CPH, CKP, strt, div, ss_sel, data_in, MISO,
    output CS, MOSI, SCK, data_out, done, busy
  );

  modport slave (
    output CPH, CKP, strt, div, ss_sel, data_in, MISO,
    input  CS, MOSI, SCK, data_out, done, busy
  );
endinterface

// File: rtl/spi_master_param.sv
// Full-duplex SPI master, all four CKP/CPH modes, one-hot active-low selects; strt-to-done latency
// is (2*DATA_W+1)*(div+1) cycles, and strt is ignored while busy (no queueing of requests).
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int N_SS   = 4,
  parameter int SEL_W  = 2,
  parameter int DIV_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  spi_master_param_if.master bus
);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_t;

  state_t            r_state;
  logic              r_cph;
  logic              r_ckp;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W:0]    r_cnt;
  logic [EDGE_W-1:0] r_edge;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_dout;
  logic [N_SS-1:0]   r_cs;
  logic              r_sck;
  logic              r_mosi;
  logic              r_done;
  logic              r_busy;

  logic              w_tick;
  logic              w_sel_ok;
  logic [EDGE_W-1:0] w_k;
  logic              w_lead;
  logic              w_last;

  assign w_tick   = (r_cnt == {1'b0, r_div});
  assign w_sel_ok = (32'(bus.ss_sel) < 32'(N_SS));
  assign w_k      = r_edge + 1'b1;
  assign w_lead   = w_k[0];
  assign w_last   = (w_k == LAST_EDGE);

  // Idle SCK follows the live polarity input; during a transfer the captured one is used.
  assign bus.SCK      = r_sck ^ ((r_state == S_IDLE) ? bus.CKP : r_ckp);
  assign bus.CS       = r_cs;
  assign bus.MOSI     = r_mosi;
  assign bus.data_out = r_dout;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cph   <= 1'b0;
      r_ckp   <= 1'b0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_edge  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_dout  <= '0;
      r_cs    <= '1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.strt && w_sel_ok) begin
            r_cph   <= bus.CPH;
            r_ckp   <= bus.CKP;
            r_div   <= bus.div;
            r_tx    <= bus.data_in;
            r_rx    <= '0;
            r_cnt   <= '0;
            r_edge  <= '0;
            r_cs    <= ~(N_SS'(1) << bus.ss_sel);
            r_mosi  <= bus.CPH ? 1'b0 : bus.data_in[DATA_W-1];
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP, S_XFER: begin
          if (w_tick) begin
            r_cnt  <= '0;
            r_edge <= w_k;
            r_sck  <= ~r_sck;
            if (w_lead) begin
              if (r_cph) begin
                r_mosi <= r_tx[DATA_W-1];
                r_tx   <= r_tx << 1;
              end else begin
                r_rx <= {r_rx[DATA_W-2:0], bus.MISO};
              end
            end else begin
              if (r_cph) begin
                r_rx <= {r_rx[DATA_W-2:0], bus.MISO};
              end else if (!w_last) begin
                // CPH=0 presents bit k/2+1 after trailing edge k; the LSB stays until DONE.
                r_mosi <= r_tx[DATA_W-2];
                r_tx   <= r_tx << 1;
              end
            end
            r_state <= w_last ? S_HOLD : S_XFER;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_cs    <= '1;
            r_mosi  <= 1'b0;
            r_dout  <= r_rx;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
